// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register with writeback data select and saturating retire counter.
// Define MEM_WB_FWD_EN to add the fwd_en/fwd_reg/fwd_data forwarding outputs.
module mem_wb_stage #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic             in_valid,
    input  logic             MemtoReg_in,
    input  logic             RegWrite_in,
    input  logic             ldurb_in,
    input  logic [4:0]       Rd_in,
    input  logic [63:0]      dm_address,
    input  logic [63:0]      dm_read_data,
    output logic             wb_valid,
    output logic             RegWrite_out,
    output logic [4:0]       wb_reg,
    output logic [63:0]      wb_data,
    output logic [CNT_W-1:0] retired
`ifdef MEM_WB_FWD_EN
    ,
    output logic             fwd_en,
    output logic [4:0]       fwd_reg,
    output logic [63:0]      fwd_data
`endif
);
    logic        valid, mtr, rw, ldurb;
    logic [4:0]  rd;
    logic [63:0] addr, rdata;
    logic        we;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid   <= 1'b0;
            mtr     <= 1'b0;
            rw      <= 1'b0;
            ldurb   <= 1'b0;
            rd      <= '0;
            addr    <= '0;
            rdata   <= '0;
            retired <= '0;
        end else if (!stall) begin
            valid <= in_valid & ~flush;
            mtr   <= MemtoReg_in;
            rw    <= RegWrite_in;
            ldurb <= ldurb_in;
            rd    <= Rd_in;
            addr  <= dm_address;
            rdata <= dm_read_data;
            if (valid && retired != {CNT_W{1'b1}})
                retired <= retired + 1'b1;
        end
    end
    // X31 is XZR: never written
    assign we           = valid & rw & (rd != 5'd31);
    assign wb_valid     = valid;
    assign RegWrite_out = we & ~stall;
    assign wb_reg       = rd;
    assign wb_data      = mtr ? (ldurb ? {56'b0, rdata[7:0]} : rdata) : addr;
`ifdef MEM_WB_FWD_EN
    assign fwd_en   = we;
    assign fwd_reg  = rd;
    assign fwd_data = wb_data;
`endif
endmodule
